// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
// Holds the result-register state encoding and the op select encoding.
package adder_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_arbiter_addsub.sv
// Combinational wrapping adder/subtractor: Sum = A + B (sel=OP_ADD) or A - B (sel=OP_SUB).
// A single carry chain; subtraction is A + ~B + 1.
module adder_arbiter_addsub
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    sel,
  output logic signed [WIDTH-1:0] Sum
);

  logic signed [WIDTH-1:0] b_eff;
  logic signed [WIDTH-1:0] cin;

  always_comb begin
    b_eff = (sel == OP_SUB) ? ~B : B;
    cin   = '0;
    cin[0] = (sel == OP_SUB);
    Sum   = A + b_eff + cin;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared add/sub unit into a single result register.
// Define ADDER_ARBITER_OVF_EN to add the registered signed-overflow flag o_res_ovf.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic             i_req0_sub,
  input  logic             i_req1_sub,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
`ifdef ADDER_ARBITER_OVF_EN
  output logic             o_res_ovf,
`endif
  output logic             o_res_id
);

  state_e                  state;
  logic                    last_p1;
  logic signed [WIDTH-1:0] data_p1;
  logic                    id_p1;

  logic                    can_accept;
  logic                    gnt0;
  logic                    gnt1;
  logic                    xfer;
  logic signed [WIDTH-1:0] op_a_p0;
  logic signed [WIDTH-1:0] op_b_p0;
  logic                    op_sub_p0;
  logic signed [WIDTH-1:0] sum_p0;

`ifdef ADDER_ARBITER_OVF_EN
  logic ovf_p1;

  function automatic logic ovf_fn(input logic a_msb, input logic b_msb,
                                  input logic sub, input logic s_msb);
    logic b_eff_msb;
    b_eff_msb = b_msb ^ sub;
    return (a_msb == b_eff_msb) && (s_msb != a_msb);
  endfunction
`endif

  // Stage p0: grant and operand select; grants drop during reset and while the result is stuck
  always_comb begin
    can_accept = !i_reset && ((state == EMPTY) || i_res_ready);
    gnt0       = can_accept && i_req0_valid && (!i_req1_valid || last_p1);
    gnt1       = can_accept && i_req1_valid && (!i_req0_valid || !last_p1);
    xfer       = gnt0 || gnt1;
    op_a_p0    = gnt1 ? i_req1_a   : i_req0_a;
    op_b_p0    = gnt1 ? i_req1_b   : i_req0_b;
    op_sub_p0  = gnt1 ? i_req1_sub : i_req0_sub;
  end

  adder_arbiter_addsub #(.WIDTH(WIDTH)) u_addsub (
    .A   (op_a_p0),
    .B   (op_b_p0),
    .sel (op_sub_p0),
    .Sum (sum_p0)
  );

  // Stage p1: result register; a refill in the same edge as a drain keeps it FULL
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= EMPTY;
      last_p1 <= 1'b1;
      data_p1 <= '0;
      id_p1   <= 1'b0;
`ifdef ADDER_ARBITER_OVF_EN
      ovf_p1  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        last_p1 <= gnt1;
        data_p1 <= sum_p0;
        id_p1   <= gnt1;
`ifdef ADDER_ARBITER_OVF_EN
        ovf_p1  <= ovf_fn(op_a_p0[WIDTH-1], op_b_p0[WIDTH-1], op_sub_p0, sum_p0[WIDTH-1]);
`endif
      end
      case (state)
        EMPTY:   if (xfer) state <= FULL;
        FULL:    if (!xfer && i_res_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;
  assign o_res_valid  = (state == FULL);
  assign o_res_data   = data_p1;
  assign o_res_id     = id_p1;
`ifdef ADDER_ARBITER_OVF_EN
  assign o_res_ovf    = ovf_p1;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (WIDTH=24): vector table plus hold and reset sequences.
// Build with ADDER_ARBITER_OVF_EN defined to also check o_res_ovf.
module tb_adder_arbiter;

  localparam int W = 24;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic         i_req0_valid, i_req1_valid;
  logic         o_req0_ready, o_req1_ready;
  logic [W-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic         i_req0_sub, i_req1_sub;
  logic         o_res_valid;
  logic         i_res_ready;
  logic [W-1:0] o_res_data;
  logic         o_res_id;
`ifdef ADDER_ARBITER_OVF_EN
  logic         o_res_ovf;
`endif

  adder_arbiter #(.WIDTH(W)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req0_valid (i_req0_valid),
    .i_req1_valid (i_req1_valid),
    .o_req0_ready (o_req0_ready),
    .o_req1_ready (o_req1_ready),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .i_req0_sub   (i_req0_sub),
    .i_req1_sub   (i_req1_sub),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_data   (o_res_data),
`ifdef ADDER_ARBITER_OVF_EN
    .o_res_ovf    (o_res_ovf),
`endif
    .o_res_id     (o_res_id)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         v0, v1;
    logic [W-1:0] a0, b0;
    logic         s0;
    logic [W-1:0] a1, b1;
    logic         s1;
    logic         rdy;
    logic         g0, g1;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         id;
    logic         ovf;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t sb_q[$];
  logic m_valid  = 1'b0;
  res_t m_res    = '0;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic id);
    res_t r;
    logic signed [W-1:0] ta, tb;
    longint la, lb, lr;
    ta = a; tb = b;
    la = ta; lb = tb;
    lr = sub ? (la - lb) : (la + lb);
    r.data = lr[W-1:0];
    r.id   = id;
    r.ovf  = (lr > longint'(8388607)) || (lr < longint'(-8388608));
    return r;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input vec_t v);
    res_t e;
    i_req0_valid = v.v0; i_req0_a = v.a0; i_req0_b = v.b0; i_req0_sub = v.s0;
    i_req1_valid = v.v1; i_req1_a = v.a1; i_req1_b = v.b1; i_req1_sub = v.s1;
    i_res_ready  = v.rdy;
    #1;
    chk("req0_ready", {31'b0, o_req0_ready}, {31'b0, v.g0});
    chk("req1_ready", {31'b0, o_req1_ready}, {31'b0, v.g1});
    if (v.g0)      sb_q.push_back(model(v.a0, v.b0, v.s0, 1'b0));
    else if (v.g1) sb_q.push_back(model(v.a1, v.b1, v.s1, 1'b1));
    @(posedge i_clk);
    #1;
    if (v.g0 || v.g1) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        m_valid = 1'b1;
        m_res   = e;
      end
    end else if (v.rdy) begin
      m_valid = 1'b0;
    end
    chk("res_valid", {31'b0, o_res_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("res_data", {8'b0, o_res_data}, {8'b0, m_res.data});
      chk("res_id", {31'b0, o_res_id}, {31'b0, m_res.id});
`ifdef ADDER_ARBITER_OVF_EN
      chk("res_ovf", {31'b0, o_res_ovf}, {31'b0, m_res.ovf});
`endif
    end
    @(negedge i_clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'b0, o_res_valid}, 32'd0);
    chk("rst_data", {8'b0, o_res_data}, 32'd0);
    chk("rst_id", {31'b0, o_res_id}, 32'd0);
    chk("rst_ready0", {31'b0, o_req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, o_req1_ready}, 32'd0);
`ifdef ADDER_ARBITER_OVF_EN
    chk("rst_ovf", {31'b0, o_res_ovf}, 32'd0);
`endif
  endtask

  initial begin
    vec_t hv;
    //            v0    v1    a0         b0         s0    a1         b1         s1    rdy   g0    g1
    vecs[0] = '{1'b1, 1'b0, 24'd5,     24'd3,     1'b0, 24'd0,     24'd0,     1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'd10,    24'd1,     1'b0, 24'd20,    24'd2,     1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 24'd10,    24'd1,     1'b0, 24'd20,    24'd2,     1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 24'd10,    24'd1,     1'b1, 24'd20,    24'd2,     1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 24'd9,     24'd9,     1'b0, 24'd0,     24'd1,     1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 24'd7,     24'd7,     1'b0, 24'd7,     24'd7,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 24'h7FFFFF, 24'd1,    1'b0, 24'd0,     24'd0,     1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 24'd1,     24'd1,     1'b0, 24'h800000, 24'd1,    1'b1, 1'b1, 1'b0, 1'b1};

    i_reset = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_res_ready = 1'b1;
    i_req0_a = '0; i_req0_b = '0; i_req1_a = '0; i_req1_b = '0;
    i_req0_sub = 1'b0; i_req1_sub = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs();
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < 8; i++) step(vecs[i]);

    // Hold: result stuck for 4 cycles with req0 waiting, then same-edge drain and refill.
    hv = '{1'b1, 1'b0, 24'd100, 24'd1, 1'b0, 24'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) step(hv);
    hv.rdy = 1'b1; hv.g0 = 1'b1;
    step(hv);

    // Asynchronous reset while FULL; last grant was 0, so the tie must still go to 0 after reset.
    #2;
    i_reset = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #1;
    check_reset_outputs();
    sb_q.delete();
    m_valid = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    hv = '{1'b1, 1'b1, 24'd40, 24'd2, 1'b0, 24'd50, 24'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    step(hv);
    hv.g0 = 1'b0; hv.g1 = 1'b1;
    step(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 24, the operand and result width in bits.
REQ-002 The module SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have ports i_req0_valid / i_req1_valid, input, 1 each, requester n has an operation pending.
REQ-005 The module SHALL have ports o_req0_ready / o_req1_ready, input-side handshake, output, 1 each, requester n is granted this cycle.
REQ-006 The module SHALL have ports i_req0_a, i_req0_b, i_req1_a, i_req1_b, input, WIDTH each, operands.
REQ-007 The module SHALL have ports i_req0_sub / i_req1_sub, input, 1 each: 0 = A+B, 1 = A-B.
REQ-008 The module SHALL have port o_res_valid, output, 1, the result register holds a result.
REQ-009 The module SHALL have port i_res_ready, input, 1, the consumer accepts the result.
REQ-010 The module SHALL have port o_res_data, output, WIDTH, result modulo 2^WIDTH.
REQ-011 The module SHALL have port o_res_id, output, 1, index of the requester that issued the result.

Function
REQ-012 A transfer on requester n SHALL occur when i_reqn_valid and o_reqn_ready are both 1 at a rising edge.
REQ-013 The ready outputs SHALL be combinational, one-hot or zero, and asserted only when the result register is empty or i_res_ready is 1 in the same cycle.
REQ-014 Arbitration SHALL be round-robin: with one requester valid it is granted; with both valid, the requester not granted last SHALL win.
REQ-015 The last-grant pointer SHALL update only on a completed transfer.
REQ-016 State machine: EMPTY (o_res_valid=0) and FULL (o_res_valid=1); EMPTY->FULL on transfer; FULL->EMPTY on i_res_ready with no transfer; FULL->FULL on i_res_ready with transfer (drain and refill in the same edge, no bubble).
REQ-017 Latency SHALL be exactly one cycle: the result of a transfer at edge k is visible on o_res_data/o_res_id after edge k.
REQ-018 While FULL and i_res_ready=0, o_res_data, o_res_id and o_res_valid SHALL be held stable and both ready outputs SHALL be 0.
REQ-019 Arithmetic SHALL wrap modulo 2^WIDTH with no saturation (e.g. 0 - 1 = all ones).
REQ-020 Operands of a non-granted requester SHALL have no effect; a valid may drop without a transfer.

Reset
REQ-021 On i_reset=1, o_res_valid SHALL go 0 immediately, o_res_data and o_res_id SHALL be 0, and the state SHALL be EMPTY.
REQ-022 Reset SHALL set the last-grant pointer to 1, so requester 0 wins the first tie.
REQ-023 A result pending at reset SHALL be discarded, and ready outputs SHALL be 0 while reset is asserted.

Configuration
REQ-024 With macro ADDER_ARBITER_OVF_EN defined, port o_res_ovf (output, 1) SHALL exist and be registered alongside o_res_data, flagging two's-complement signed overflow of the operation, reset to 0.
REQ-025 Without ADDER_ARBITER_OVF_EN, o_res_ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package SHALL hold the state enum (EMPTY, FULL) and the op encoding constants OP_ADD=0, OP_SUB=1.
REQ-027 The arithmetic SHALL be performed by one instance of the team's existing combinational add/sub module (A, B, sel, Sum) at the arbiter's WIDTH; no second adder is permitted.

Verification (WIDTH=24)
REQ-028 After reset, req0 valid with a=5, b=3, sub=0, i_res_ready=1 -> o_req0_ready=1; next cycle o_res_valid=1, o_res_data=8, o_res_id=0.
REQ-029 Both requesters valid every cycle, i_res_ready=1 -> grants alternate 0,1,0,1 and o_res_id follows with one cycle lag.
REQ-030 req1 a=0, b=1, sub=1 -> o_res_data=0xFFFFFF; with ADDER_ARBITER_OVF_EN, a=0x7FFFFF, b=1, sub=0 -> o_res_ovf=1.
REQ-031 Result held with i_res_ready=0 for 4 cycles while req0 valid -> outputs stable, o_req0_ready=0; i_res_ready raised -> same-edge drain and refill, o_res_valid stays 1.
REQ-032 i_reset asserted mid-cycle while FULL -> o_res_valid=0 before the next edge; after release, a tie grants requester 0.
